// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button inputs and conditioned pulse outputs
interface button_conditioner_if #(
   parameter int N_BTN = 6
);
   logic [N_BTN-1:0] i_btn;
   logic [N_BTN-1:0] o_level;
   logic [N_BTN-1:0] o_press;
   logic [N_BTN-1:0] o_release;
   logic [N_BTN-1:0] o_rep;

   modport master (
      output i_btn,
      input  o_level, o_press, o_release, o_rep
   );

   modport slave (
      input  i_btn,
      output o_level, o_press, o_release, o_rep
   );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-channel sync, debounce, edge pulses and auto-repeat
module button_conditioner #(
   parameter int               N_BTN           = 6,
   parameter int               DEBOUNCE_CYCLES = 1_000_000,
   parameter int               REPEAT_DELAY    = 50_000_000,
   parameter int               REPEAT_RATE     = 10_000_000,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(6'b000111)
) (
   input  logic                 clk,
   input  logic                 rst,
   button_conditioner_if.slave  bus
);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW   = $clog2(RMAX + 1);

   localparam logic [DW-1:0] D_TERM    = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_TERM  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_TERM = RW'(REPEAT_RATE - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DELAY = 2'd1;
   localparam logic [1:0] ST_RATE  = 2'd2;

   logic [N_BTN-1:0] level_vec;
   logic [N_BTN-1:0] press_vec;
   logic [N_BTN-1:0] release_vec;
   logic [N_BTN-1:0] rep_vec;

   for (genvar k = 0; k < N_BTN; k++) begin : g_ch
      logic          sync1_q, sync2_q;
      logic          stable_q, stable_d;
      logic          level_q, press_q, release_q;
      logic [DW-1:0] dcnt_q, dcnt_d;
      logic [1:0]    state_q, state_d;
      logic [RW-1:0] rcnt_q, rcnt_d;
      logic          rep_fire;

      // Count only consecutive disagreeing samples; any agreement restarts the run.
      always_comb begin
         stable_d = stable_q;
         dcnt_d   = '0;
         if (sync2_q != stable_q) begin
            if (dcnt_q == D_TERM) begin
               stable_d = sync2_q;
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
      end

      // level_q gates the pulse so a count expiring in the release cycle is dropped.
      assign rep_fire = level_q &&
                        (((state_q == ST_DELAY) && (rcnt_q == DLY_TERM)) ||
                         ((state_q == ST_RATE)  && (rcnt_q == RATE_TERM)));

      always_comb begin
         state_d = state_q;
         rcnt_d  = rcnt_q;
         case (state_q)
            ST_IDLE: begin
               if (press_q) begin
                  state_d = ST_DELAY;
                  rcnt_d  = '0;
               end
            end
            ST_DELAY: begin
               if (!level_q) begin
                  state_d = ST_IDLE;
                  rcnt_d  = '0;
               end else if (rcnt_q == DLY_TERM) begin
                  state_d = ST_RATE;
                  rcnt_d  = '0;
               end else begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
            ST_RATE: begin
               if (!level_q) begin
                  state_d = ST_IDLE;
                  rcnt_d  = '0;
               end else if (rcnt_q == RATE_TERM) begin
                  rcnt_d = '0;
               end else begin
                  rcnt_d = rcnt_q + RW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               rcnt_d  = '0;
            end
         endcase
         if (!REPEAT_MASK[k]) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= ST_IDLE;
            rcnt_q    <= '0;
         end else begin
            sync1_q   <= bus.i_btn[k];
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            dcnt_q    <= dcnt_d;
            level_q   <= stable_q;
            press_q   <= stable_q & ~level_q;
            release_q <= ~stable_q & level_q;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
         end
      end

      assign level_vec[k]   = level_q;
      assign press_vec[k]   = press_q;
      assign release_vec[k] = release_q;
      assign rep_vec[k]     = press_q | rep_fire;
   end

   assign bus.o_level   = level_vec;
   assign bus.o_press   = press_vec;
   assign bus.o_release = release_vec;
   assign bus.o_rep     = rep_vec;
endmodule
